snax_gemmx_d32_serializer: RTL

Width-adaptation stage directly downstream of the GEMMX accelerator's 32-bit result port (D32, 2048 bits). It captures one wide result word per handshake and emits it as `Ratio` consecutive narrow beats to a streamer write port of `OutWidth` bits, low slice first, with full valid/ready back-pressure in both directions. It also counts completed wide words so software can check result progress.

---
 rtl/snax_gemmx_d32_serializer.sv | 109 ++++++++++
 1 files changed

// File: rtl/snax_gemmx_d32_serializer.sv
// Wide-to-narrow serializer behind the GEMMX D32 result port.
// Captures one InWidth word per handshake and replays it as Ratio beats of
// OutWidth bits, lowest slice first, with valid/ready on both sides.
// Also keeps a wrapping count of fully emitted wide words.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | nothing held, ready for a wide word, no beat offered
// ST_SEND | wide word held, offering slice r_beat downstream
module snax_gemmx_d32_serializer #(
  parameter int InWidth  = 2048,
  parameter int OutWidth = 512,
  parameter int CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [InWidth-1:0]  in_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [OutWidth-1:0] out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  input  logic                cnt_clear_i,
  output logic [CntWidth-1:0] words_done_o,
  output logic                busy_o
);

  localparam int Ratio = InWidth / OutWidth;
  localparam int BeatW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Ratio - 1);

  if (((InWidth % OutWidth) != 0) || (Ratio < 2)) begin : g_bad_ratio
    $error("snax_gemmx_d32_serializer: InWidth/OutWidth must be an integer >= 2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e                          r_state;
  logic [InWidth-1:0]              r_hold;
  logic [BeatW-1:0]                r_beat;
  logic [CntWidth-1:0]             r_words_done;
  logic                            r_out_valid;
  logic                            r_busy;

  logic                            w_last_hs;
  logic                            w_in_ready;
  logic [Ratio-1:0][OutWidth-1:0]  w_slices;

  // The last beat leaving frees the hold register in the same cycle, which is
  // what allows a new word to chain in without a bubble.
  assign w_last_hs  = (r_state == ST_SEND) & out_ready_i & (r_beat == LastBeat);
  assign w_in_ready = (r_state == ST_IDLE) | w_last_hs;

  assign w_slices     = r_hold;
  assign out_data_o   = w_slices[r_beat];
  assign out_valid_o  = r_out_valid;
  assign in_ready_o   = w_in_ready;
  assign busy_o       = r_busy;
  assign words_done_o = r_words_done;

  // Sequencing FSM: capture, step through beats, chain or return to idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (in_valid_i) begin
          r_hold      <= in_data_i;
          r_beat      <= '0;
          r_state     <= ST_SEND;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b1;
        end
      end else begin
        if (out_ready_i) begin
          if (r_beat != LastBeat) begin
            r_beat <= r_beat + BeatW'(1);
          end else if (in_valid_i) begin
            r_hold <= in_data_i;
            r_beat <= '0;
          end else begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
      end
    end
  end

  // Completed-word counter; a clear in the same cycle as a last beat wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_words_done <= '0;
    end else if (cnt_clear_i) begin
      r_words_done <= '0;
    end else if (w_last_hs) begin
      r_words_done <= r_words_done + CntWidth'(1);
    end
  end

endmodule
